// File: rtl/ds18b20_sequencer.sv
// ds18b20_sequencer: DS18B20 measurement sequencer (reset, skip ROM, convert, reset, skip ROM, read scratchpad).
// Define DS18B20_CRC8_EN to check the scratchpad CRC-8 before accepting the temperature.
module ds18b20_sequencer #(
    parameter int CONV_TICKS = 1_500_000,
    parameter int RD_BYTES   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic [15:0] temp,
    output logic        temp_vld,
    output logic        err_nopres,
    output logic        crc_err,
    output logic        ow_rst_req,
    input  logic        ow_rst_done,
    input  logic        ow_presence,
    output logic        ow_vld,
    output logic        ow_we,
    output logic [3:0]  ow_bits,
    output logic [7:0]  ow_wdat,
    input  logic [7:0]  ow_rdat,
    input  logic        ow_done
);
    localparam int CW = CONV_TICKS > 1 ? $clog2(CONV_TICKS) : 1;
    localparam int IW = $clog2(RD_BYTES);

    typedef enum logic [3:0] {
        IDLE, RST1, SKIP1, CONV, WAIT, RST2, SKIP2, RDCMD, RDBYTE, CHECK, DONE, ERROR
    } state_t;

    state_t state, nxt;
    logic fresh, nopres, dn, rd, last, pass;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [7:0] b0, b1;

`ifdef DS18B20_CRC8_EN
    logic [7:0] crc;
    logic ok;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 8'h8C) : (r >> 1);
        return r;
    endfunction

    assign pass = ok;
`else
    assign pass = 1'b1;
`endif

    // completions are only honoured once the request has been presented for a cycle
    assign dn   = ow_done && !fresh;
    assign rd   = ow_rst_done && !fresh;
    assign last = idx == IW'(RD_BYTES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            fresh  <= 1'b0;
            nopres <= 1'b0;
            cnt    <= '0;
            idx    <= '0;
            b0     <= '0;
            b1     <= '0;
            temp   <= '0;
`ifdef DS18B20_CRC8_EN
            crc    <= '0;
            ok     <= 1'b0;
`endif
        end else begin
            state <= nxt;
            fresh <= nxt != state || (state == RDBYTE && dn && !last);
            if (state == CONV && dn)
                cnt <= CW'(CONV_TICKS - 1);
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - CW'(1);
            if (state == RDCMD)
                idx <= '0;
            else if (state == RDBYTE && dn) begin
                idx <= idx + IW'(1);
                b0  <= idx == '0 ? ow_rdat : b0;
                b1  <= idx == IW'(1) ? ow_rdat : b1;
            end
`ifdef DS18B20_CRC8_EN
            if (state == RDCMD)
                crc <= '0;
            else if (state == RDBYTE && dn) begin
                crc <= crc8(crc, ow_rdat);
                ok  <= crc == ow_rdat;
            end
`endif
            if (nxt == ERROR)
                nopres <= state != CHECK;
            if (state == CHECK && pass)
                temp <= {b1, b0};
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? RST1 : IDLE;
            RST1:    nxt = rd ? (ow_presence ? SKIP1 : ERROR) : RST1;
            SKIP1:   nxt = dn ? CONV : SKIP1;
            CONV:    nxt = dn ? WAIT : CONV;
            WAIT:    nxt = cnt == '0 ? RST2 : WAIT;
            RST2:    nxt = rd ? (ow_presence ? SKIP2 : ERROR) : RST2;
            SKIP2:   nxt = dn ? RDCMD : SKIP2;
            RDCMD:   nxt = dn ? RDBYTE : RDCMD;
            RDBYTE:  nxt = dn && last ? CHECK : RDBYTE;
            CHECK:   nxt = pass ? DONE : ERROR;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = state != IDLE;
        ow_rst_req = fresh && (state == RST1 || state == RST2);
        ow_vld     = fresh && state inside {SKIP1, CONV, SKIP2, RDCMD, RDBYTE};
        ow_we      = state inside {SKIP1, CONV, SKIP2, RDCMD};
        ow_bits    = 4'd8;
        ow_wdat    = (state == SKIP1 || state == SKIP2) ? 8'hCC :
                     state == CONV  ? 8'h44 :
                     state == RDCMD ? 8'hBE : 8'h00;
        temp_vld   = state == DONE;
        err_nopres = state == ERROR && nopres;
`ifdef DS18B20_CRC8_EN
        crc_err    = state == ERROR && !nopres;
`else
        crc_err    = 1'b0;
`endif
    end
endmodule

// File: tb/tb_ds18b20_sequencer.sv
// tb_ds18b20_sequencer: randomized 1-Wire responder plus transaction-level model of one measurement.
module tb_ds18b20_sequencer;
    localparam int TICKS = 4;

    logic clk = 0, rst = 1, start = 0;
    logic ow_rst_done = 0, ow_presence = 0, ow_done = 0;
    logic [7:0] ow_rdat = 0;
    logic busy, temp_vld, err_nopres, crc_err, ow_rst_req, ow_vld, ow_we;
    logic [15:0] temp;
    logic [3:0] ow_bits;
    logic [7:0] ow_wdat;

    ds18b20_sequencer #(.CONV_TICKS(TICKS), .RD_BYTES(9)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .temp(temp), .temp_vld(temp_vld),
        .err_nopres(err_nopres), .crc_err(crc_err), .ow_rst_req(ow_rst_req),
        .ow_rst_done(ow_rst_done), .ow_presence(ow_presence), .ow_vld(ow_vld), .ow_we(ow_we),
        .ow_bits(ow_bits), .ow_wdat(ow_wdat), .ow_rdat(ow_rdat), .ow_done(ow_done)
    );

    always #5 clk = ~clk;

    int ncmp = 0, nerr = 0;
    logic [7:0] sp [9];
    bit p1 = 1, p2 = 1, en = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        ncmp++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, a, e);
        end
    endtask

    function automatic logic [7:0] crc_sp();
        logic [7:0] c = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                c = (c[0] ^ sp[i][j]) ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        return c;
    endfunction

    task automatic set_good();
        logic [7:0] g [9] = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
        for (int i = 0; i < 9; i++) sp[i] = g[i];
    endtask

    // measurement as a list of bus operations: 0 reset, 1 write, 2 read, 3 conversion wait
    function automatic int kind(input int i);
        return (i == 0 || i == 4) ? 0 : (i == 3) ? 3 : (i < 7) ? 1 : 2;
    endfunction
    function automatic logic [7:0] dat(input int i);
        return (i == 1 || i == 5) ? 8'hCC : (i == 2) ? 8'h44 : (i == 6) ? 8'hBE : 8'h00;
    endfunction

    // responder: acknowledges resets and byte transfers after random latency, injects stray pulses in WAIT
    int rcd = 0, xcd = 0, rdi = 0, rn = 0;
    bit xwe, wwin = 0, fired;
    logic [7:0] xdat;
    initial begin
        forever begin
            @(posedge clk); #2;
            ow_done = 0; ow_rst_done = 0; ow_presence = 0;
            if (!busy) rn = 0;
            if (rst) begin
                rcd = 0; xcd = 0; wwin = 0; rdi = 0;
            end else begin
                if (ow_rst_req) wwin = 0;
                fired = 0;
                if (rcd > 0) begin
                    rcd--;
                    if (rcd == 0) begin
                        ow_rst_done = 1; ow_presence = (rn == 1) ? p1 : p2; fired = 1;
                    end
                end
                if (xcd > 0) begin
                    xcd--;
                    if (xcd == 0) begin
                        ow_done = 1; fired = 1;
                        ow_rdat = xwe ? 8'($urandom) : sp[rdi];
                        if (!xwe) rdi++;
                        if (xwe && xdat == 8'h44) wwin = 1;
                    end
                end
                if (!fired && wwin && $urandom % 3 == 0) begin
                    ow_done = 1; ow_rdat = 8'($urandom);
                    if ($urandom % 2 == 1) begin ow_rst_done = 1; ow_presence = 1'($urandom); end
                end
                if (ow_rst_req) begin rcd = $urandom_range(1, 4); rn++; rdi = 0; end
                if (ow_vld) begin xcd = $urandom_range(1, 5); xwe = ow_we; xdat = ow_wdat; end
            end
        end
    end

    // model state
    bit m_busy = 0, iss = 0, waiting = 0, pulse, evld, erq, etv, enp, ecr;
    int op_i = 0, outst = 0, wc = 0, res_cd = 0, res_k = 0, cyc = 0;
    int n_tv = 0, n_np = 0, n_ce = 0, n_vld = 0, t_conv = 0, t_rq2 = 0;
    logic [15:0] m_temp = 0;

    always @(negedge clk) begin
        if (en) begin
            cyc++;
            pulse = 0; etv = 0; enp = 0; ecr = 0;
            if (res_cd > 0) begin
                res_cd--;
                if (res_cd == 0) begin
                    pulse = 1; etv = res_k == 0; enp = res_k == 1; ecr = res_k == 2;
                    if (etv) m_temp = {sp[1], sp[0]};
                end
            end
            evld = iss && (kind(op_i) == 1 || kind(op_i) == 2);
            erq  = iss && kind(op_i) == 0;
            chk("busy", busy, m_busy);
            chk("ow_vld", ow_vld, evld);
            chk("ow_rst_req", ow_rst_req, erq);
            chk("temp_vld", temp_vld, etv);
            chk("err_nopres", err_nopres, enp);
            chk("crc_err", crc_err, ecr);
            chk("temp", temp, m_temp);
            chk("ow_bits", ow_bits, 8);
            if (temp_vld === 1) n_tv++;
            if (err_nopres === 1) n_np++;
            if (crc_err === 1) n_ce++;
            if (ow_vld === 1) n_vld++;
            if (erq && op_i == 4) t_rq2 = cyc;
            if (evld) outst = 1;
            if (erq) outst = 2;
            iss = 0;
            if (outst == 1) begin
                chk("ow_we", ow_we, kind(op_i) == 1);
                chk("ow_wdat", ow_wdat, dat(op_i));
            end
            if (!m_busy) begin
                chk("idle_we", ow_we, 0);
                chk("idle_wdat", ow_wdat, 0);
            end
            if (waiting) begin
                wc++;
                if (wc == TICKS) begin waiting = 0; op_i = 4; iss = 1; end
            end
            if (ow_done && outst == 1) begin
                outst = 0;
                if (op_i == 2) begin waiting = 1; wc = 0; op_i = 3; t_conv = cyc; end
                else if (op_i == 15) begin
                    res_cd = 2; op_i = 16;
`ifdef DS18B20_CRC8_EN
                    res_k = (crc_sp() != sp[8]) ? 2 : 0;
`else
                    res_k = 0;
`endif
                end else begin op_i++; iss = 1; end
            end
            if (ow_rst_done && outst == 2) begin
                outst = 0;
                if (ow_presence) begin op_i++; iss = 1; end
                else begin res_cd = 1; res_k = 1; end
            end
            if (pulse) m_busy = 0;
            else if (!m_busy && start) begin m_busy = 1; op_i = 0; iss = 1; end
            if (rst) begin
                m_busy = 0; iss = 0; waiting = 0; outst = 0; res_cd = 0; op_i = 0; m_temp = 0;
            end
        end
    end

    task automatic meas(input bit a, input bit b);
        p1 = a; p2 = b;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (!m_busy) begin start = 0; return; end
            start = ($urandom % 6 == 0);
        end
        start = 0;
        ncmp++; nerr++;
        $display("FAIL timeout: measurement still busy after 3000 cycles");
    endtask

    int c_tv, c_np, c_ce, c_vld;
    bit hit;
    initial begin
        set_good();
        @(posedge clk); #1;
        en = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_temp", temp, 16'h0000);
        chk("rst_we", ow_we, 0);
        chk("rst_wdat", ow_wdat, 8'h00);
        chk("rst_bits", ow_bits, 4'd8);
        chk("crc_literal", crc_sp(), 8'h1C);
        @(posedge clk); #1;

        sp[8] = 8'h1D;
        c_tv = n_tv; c_ce = n_ce;
        meas(1, 1);
`ifdef DS18B20_CRC8_EN
        chk("badcrc_pulses", n_ce - c_ce, 1);
        chk("badcrc_temp", temp, 16'h0000);
`else
        chk("badcrc_nocheck_temp", temp, 16'h0550);
        chk("badcrc_nocheck_tv", n_tv - c_tv, 1);
`endif

        set_good();
        c_np = n_np; c_vld = n_vld;
        meas(0, 1);
        chk("nopres_pulses", n_np - c_np, 1);
        chk("nopres_vld", n_vld - c_vld, 0);
        chk("nopres_busy", busy, 0);

        c_tv = n_tv; c_ce = n_ce; c_vld = n_vld;
        meas(1, 1);
        chk("good_temp", temp, 16'h0550);
        chk("good_tv", n_tv - c_tv, 1);
        chk("good_crc", n_ce - c_ce, 0);
        chk("good_xfers", n_vld - c_vld, 13);
        chk("wait_cycles", t_rq2 - t_conv - 1, TICKS);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 9; i++) sp[i] = 8'($urandom);
            if ($urandom % 4 != 0) sp[8] = crc_sp();
            meas($urandom % 8 != 0, $urandom % 8 != 0);
        end

        set_good();
        p1 = 1; p2 = 1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        hit = 0;
        for (int k = 0; k < 3000 && !hit; k++) begin
            @(posedge clk); #1;
            hit = (op_i == 10 && outst == 1);
        end
        if (!hit) begin
            ncmp++; nerr++;
            $display("FAIL abort_reach: read of byte 3 never issued");
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_temp", temp, 16'h0000);
        chk("abort_vld", ow_vld, 0);
        chk("abort_rreq", ow_rst_req, 0);
        chk("abort_we", ow_we, 0);
        chk("abort_wdat", ow_wdat, 8'h00);
        @(posedge clk); #1;
        c_tv = n_tv;
        meas(1, 1);
        chk("post_abort_temp", temp, 16'h0550);
        chk("post_abort_tv", n_tv - c_tv, 1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
